// File: rtl/rv_div_pkg.sv
// Shared types for the iterative RV32M divider: op and FSM encodings, default width.
package rv_div_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  // DIV and REM treat operands as two's-complement; DIVU/REMU as unsigned.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/rv_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, select.
module rv_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN:0]   o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0]   w_shift;
  logic [XLEN+1:0] w_diff;
  logic            w_neg;

  // Trial subtract with one guard bit so the borrow shows up as the sign.
  always_comb begin
    w_shift = {i_rem[XLEN-1:0], i_quo[XLEN-1]};
    w_diff  = {1'b0, w_shift} - {2'b00, i_divisor};
    w_neg   = w_diff[XLEN+1] & ~i_rem[XLEN];
    o_rem   = w_neg ? w_shift : w_diff[XLEN:0];
    o_quo   = {i_quo[XLEN-2:0], ~w_neg};
  end

endmodule

// File: rtl/rv_divider.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one restoring step per cycle.
// Optional macro RV_DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow
// skip the iteration phase and finish two cycles after accept.
module rv_divider
  import rv_div_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned CW = $clog2(XLEN);

  state_e          r_state, w_next;
  op_e             r_op;
  logic            r_qsign, r_rsign;
  logic [XLEN-1:0] r_dvsr, r_quo, r_result;
  logic [XLEN:0]   r_rem;
  logic [CW-1:0]   r_cnt;

  logic            w_accept, w_signed, w_a_neg, w_b_neg, w_div0, w_special;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_step_quo, w_fix;
  logic [XLEN:0]   w_step_rem;

  assign w_signed = op_is_signed(i_op);
  assign w_a_neg  = w_signed & i_dividend[XLEN-1];
  assign w_b_neg  = w_signed & i_divisor[XLEN-1];
  assign w_a_mag  = w_a_neg ? -i_dividend : i_dividend;
  assign w_b_mag  = w_b_neg ? -i_divisor : i_divisor;
  assign w_div0   = (i_divisor == '0);
  assign w_accept = i_start & ~i_flush & ((r_state == S_IDLE) | (r_state == S_DONE));

`ifdef RV_DIV_FAST_SPECIAL_EN
  assign w_special = w_div0 |
                     (w_signed & (i_dividend == {1'b1, {(XLEN-1){1'b0}}}) & (i_divisor == '1));
`else
  assign w_special = 1'b0;
`endif

  rv_div_step #(.XLEN(XLEN)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_dvsr),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  // Final sign correction of the selected quotient or remainder.
  always_comb begin
    w_fix = '0;
    if ((r_op == OP_REM) || (r_op == OP_REMU))
      w_fix = r_rsign ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
    else
      w_fix = r_qsign ? -r_quo : r_quo;
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; flush wins over any simultaneous start.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = w_accept ? (w_special ? S_FIX : S_CALC) : S_IDLE;
      S_CALC: begin
        if (i_flush)                       w_next = S_IDLE;
        else if (r_cnt == CW'(XLEN - 1))   w_next = S_FIX;
      end
      S_FIX:   w_next = i_flush ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  assign o_busy   = (r_state == S_CALC) | (r_state == S_FIX);
  assign o_valid  = (r_state == S_DONE) & ~i_flush;
  assign o_result = r_result;

  // Operand capture, iteration and result register.
  // Quotient sign is cleared for divide-by-zero so the all-ones quotient survives
  // FIX; the fast path preloads the final magnitudes and lets FIX apply signs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op     <= OP_DIV;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_dvsr   <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op    <= op_e'(i_op);
      r_qsign <= (w_a_neg ^ w_b_neg) & ~w_div0;
      r_rsign <= w_a_neg;
      r_dvsr  <= w_b_mag;
      r_cnt   <= '0;
      if (w_special) begin
        r_quo <= w_div0 ? '1 : w_a_mag;
        r_rem <= w_div0 ? {1'b0, w_a_mag} : '0;
      end else begin
        r_quo <= w_a_mag;
        r_rem <= '0;
      end
    end else if (r_state == S_CALC) begin
      r_quo <= w_step_quo;
      r_rem <= w_step_rem;
      r_cnt <= r_cnt + 1'b1;
    end else if ((r_state == S_FIX) && !i_flush) begin
      r_result <= w_fix;
    end
  end

endmodule

// File: tb/tb_rv_divider.sv
// Directed self-checking bench for rv_divider (XLEN=32).
module tb_rv_divider;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;
`ifdef RV_DIV_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 2;
`else
  localparam int SPEC_LAT = 34;
`endif

  logic        clk, rst_n, i_start, i_flush;
  logic [1:0]  i_op;
  logic [31:0] i_dividend, i_divisor;
  logic        o_busy, o_valid;
  logic [31:0] o_result;

  int n_checks = 0;
  int n_pass   = 0;

  rv_divider #(.XLEN(32)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .i_flush    (i_flush),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_result   (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Issue one operation from idle; lat = posedges from accept edge (inclusive) until o_valid.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    i_op = op; i_dividend = a; i_divisor = b; i_start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    i_start = 1'b0;
    while (!o_valid && lat < 100) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    res = o_result;
    if (!o_valid) lat = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_start = 1'b0; i_flush = 1'b0; i_op = DIV; i_dividend = '0; i_divisor = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", o_busy); else n_pass++;
    n_checks++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", o_valid); else n_pass++;
    n_checks++; if (o_result !== 32'h0) $display("FAIL reset_result: got %h expected 0", o_result); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned;
    logic [1:0]  ops [5] = '{DIVU, REMU, DIVU, DIVU, REMU};
    logic [31:0] as  [5] = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] bs  [5] = '{32'd7, 32'd7, 32'd1, 32'd100, 32'h0001_0000};
    logic [31:0] ex  [5] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'h0000_FFFF};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat);
      n_checks++;
      if (res !== ex[i]) $display("FAIL unsigned[%0d]: got %h expected %h", i, res, ex[i]);
      else n_pass++;
      n_checks++;
      if (lat !== 34) $display("FAIL unsigned_lat[%0d]: got %0d expected 34", i, lat);
      else n_pass++;
    end
  endtask

  task automatic test_signed;
    logic [1:0]  ops [6] = '{DIV, REM, DIV, REM, DIV, REM};
    logic [31:0] as  [6] = '{-32'sd7, -32'sd7, 32'd7, 32'd7, -32'sd8, -32'sd100};
    logic [31:0] bs  [6] = '{32'd2, 32'd2, -32'sd2, -32'sd2, -32'sd2, -32'sd7};
    logic [31:0] ex  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd4, 32'hFFFF_FFFE};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat);
      n_checks++;
      if (res !== ex[i]) $display("FAIL signed[%0d]: got %h expected %h", i, res, ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_special;
    logic [1:0]  ops [7] = '{DIV, REM, DIVU, REMU, DIV, REM, DIV};
    logic [31:0] as  [7] = '{32'd5, 32'd5, 32'd5, 32'hDEAD_BEEF, -32'sd5, -32'sd5, 32'h8000_0000};
    logic [31:0] bs  [7] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] ex  [7] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hDEAD_BEEF,
                             32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat);
      n_checks++;
      if (res !== ex[i]) $display("FAIL special[%0d]: got %h expected %h", i, res, ex[i]);
      else n_pass++;
      n_checks++;
      if (lat !== SPEC_LAT) $display("FAIL special_lat[%0d]: got %0d expected %0d", i, lat, SPEC_LAT);
      else n_pass++;
    end
    run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    n_checks++; if (res !== 32'h0) $display("FAIL ovf_rem: got %h expected 0", res); else n_pass++;
    // Same operands unsigned are an ordinary divide.
    run_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    n_checks++; if (res !== 32'h0) $display("FAIL ovf_divu: got %h expected 0", res); else n_pass++;
    n_checks++; if (lat !== 34) $display("FAIL ovf_divu_lat: got %0d expected 34", lat); else n_pass++;
  endtask

  task automatic test_busy_start;
    int cyc, nval, first;
    logic [31:0] resv;
    nval = 0; first = 0; resv = '0;
    @(negedge clk);
    i_op = DIVU; i_dividend = 32'd1000; i_divisor = 32'd10; i_start = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    i_start = 1'b0;
    while (cyc < 80) begin
      if (cyc == 10) begin
        n_checks++; if (o_busy !== 1'b1) $display("FAIL busy_mid: got %b expected 1", o_busy); else n_pass++;
        i_op = REMU; i_dividend = 32'd50; i_divisor = 32'd5; i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      @(posedge clk); cyc++; @(negedge clk);
      if (o_valid) begin
        nval++;
        if (first == 0) begin first = cyc; resv = o_result; end
      end
    end
    i_start = 1'b0;
    n_checks++; if (nval !== 1) $display("FAIL busy_nvalid: got %0d expected 1", nval); else n_pass++;
    n_checks++; if (first !== 34) $display("FAIL busy_lat: got %0d expected 34", first); else n_pass++;
    n_checks++; if (resv !== 32'd100) $display("FAIL busy_result: got %h expected %h", resv, 32'd100); else n_pass++;
    n_checks++; if (o_result !== 32'd100) $display("FAIL result_hold: got %h expected %h", o_result, 32'd100); else n_pass++;
  endtask

  task automatic test_flush_reset;
    int cyc, nval;
    logic [31:0] res;
    int lat;
    nval = 0;
    @(negedge clk);
    i_op = DIVU; i_dividend = 32'd100; i_divisor = 32'd7; i_start = 1'b1;
    @(posedge clk); cyc = 1; @(negedge clk); i_start = 1'b0;
    while (cyc < 15) begin @(posedge clk); cyc++; @(negedge clk); if (o_valid) nval++; end
    i_flush = 1'b1;
    @(posedge clk); @(negedge clk);
    i_flush = 1'b0;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL flush_busy: got %b expected 0", o_busy); else n_pass++;
    repeat (40) begin @(posedge clk); @(negedge clk); if (o_valid) nval++; end
    n_checks++; if (nval !== 0) $display("FAIL flush_valid: got %0d pulses expected 0", nval); else n_pass++;
    // Flush together with start from idle: start must not be taken.
    i_start = 1'b1; i_flush = 1'b1;
    @(posedge clk); @(negedge clk);
    i_start = 1'b0; i_flush = 1'b0;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL flush_start: got busy %b expected 0", o_busy); else n_pass++;
    // Second operation, reset mid-flight.
    i_op = DIVU; i_dividend = 32'd100; i_divisor = 32'd7; i_start = 1'b1;
    @(posedge clk); cyc = 1; @(negedge clk); i_start = 1'b0;
    while (cyc < 20) begin @(posedge clk); cyc++; @(negedge clk); if (o_valid) nval++; end
    rst_n = 1'b0;
    #1;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", o_busy); else n_pass++;
    n_checks++; if (o_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", o_valid); else n_pass++;
    n_checks++; if (o_result !== 32'h0) $display("FAIL rst_result: got %h expected 0", o_result); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); @(negedge clk); if (o_valid) nval++; end
    n_checks++; if (nval !== 0) $display("FAIL rst_novalid: got %0d pulses expected 0", nval); else n_pass++;
    run_op(DIVU, 32'd9, 32'd3, res, lat);
    n_checks++; if (res !== 32'd3) $display("FAIL post_rst_result: got %h expected 3", res); else n_pass++;
    n_checks++; if (lat !== 34) $display("FAIL post_rst_lat: got %0d expected 34", lat); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] res;
    int lat, gap;
    run_op(DIVU, 32'd100, 32'd7, res, lat);
    n_checks++; if (res !== 32'd14) $display("FAIL b2b_first: got %h expected %h", res, 32'd14); else n_pass++;
    // Still in the DONE cycle: raise start for the next op.
    i_op = DIVU; i_dividend = 32'd8; i_divisor = 32'd2; i_start = 1'b1;
    @(posedge clk); gap = 1; @(negedge clk); i_start = 1'b0;
    n_checks++; if (o_busy !== 1'b1) $display("FAIL b2b_busy: got %b expected 1", o_busy); else n_pass++;
    while (!o_valid && gap < 100) begin @(posedge clk); gap++; @(negedge clk); end
    n_checks++; if (gap !== 34) $display("FAIL b2b_gap: got %0d expected 34", gap); else n_pass++;
    n_checks++; if (o_result !== 32'd4) $display("FAIL b2b_second: got %h expected 4", o_result); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_busy_start();
    test_flush_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
